meas_buf: RTL and testbench
===========================

# meas_buf

Parametrised capture buffer for the measurement path: accepts a stream of measurement words over a valid/ready handshake, stores them in an internal C_MEMSIZE-word RAM, and returns them in arrival order over a registered valid/ready read port. It supersedes the bare address-driven memory. It adds auto-incrementing pointers, occupancy tracking, a runtime-selectable stop-when-full or circular-overwrite mode, a sticky overflow flag and a synchronous clear. It sits between the measurement sampler and the readout/serialiser logic.

## Interface
- C_WORDSIZE, 8, data word width in bits
- C_ADDRSIZE, 10, RAM address width
- C_MEMSIZE, 1 << C_ADDRSIZE, RAM depth; must equal 1 << C_ADDRSIZE (not overridden independently)

- I_clk  in  1  single clock; all state changes on rising edge
- I_rst  in  1  asynchronous, active-high reset
- I_clear  in  1  synchronous clear of pointers, count, output register, overflow flag
- I_mode  in  1  0 = stop when full, 1 = circular overwrite; sampled every cycle
- I_wr_valid  in  1  write word offered
- I_wr_data  in  C_WORDSIZE  write word
- O_wr_ready  out  1  write accepted when I_wr_valid & O_wr_ready
- O_rd_valid  out  1  O_rd_data holds a word
- O_rd_data  out  C_WORDSIZE  oldest unread word (registered)
- I_rd_ready  in  1  consumer takes word when O_rd_valid & I_rd_ready
- O_count  out  C_ADDRSIZE+1  words held in RAM (0..C_MEMSIZE); excludes the output register
- O_full  out  1  O_count == C_MEMSIZE
- O_empty  out  1  O_count == 0 and O_rd_valid == 0
- O_ovf  out  1  sticky: at least one unread word was overwritten

## Operation
- State: wr_ptr, rd_ptr (C_ADDRSIZE bits, natural wrap), count, output register with valid bit, ovf flag.
- O_wr_ready = I_mode ? 1 : !O_full. This is combinational from I_mode and the registered count.
- push = I_wr_valid & O_wr_ready. A push writes RAM[wr_ptr], then wr_ptr+1.
- pop = (count != 0) & (!O_rd_valid | I_rd_ready). A pop loads the output register from RAM[rd_ptr], then rd_ptr+1 and O_rd_valid = 1.
- If there is no pop and the consumer takes a word (O_rd_valid & I_rd_ready), O_rd_valid goes to 0 next cycle.
- Count update: push only -> +1. Pop only -> -1. Push & pop -> unchanged.
- Overwrite case: push while O_full, I_mode = 1 and no pop in the same cycle.
  - Writes RAM[wr_ptr] (== rd_ptr). Both pointers advance. Count stays C_MEMSIZE. O_ovf is set.
  - The word already in the output register is preserved.
- Push & pop while full, same address: RAM read-before-write. The output register gets the old word, count stays unchanged, O_ovf is not set.
- I_clear has the highest priority.
  - Pointers, count, O_rd_valid and O_ovf go to 0.
  - A push or pop in the same cycle is discarded.
  - O_rd_data holds its value (don't care while invalid).
- A mode change affects O_wr_ready in the same cycle and the overwrite decision for that cycle. Stored data is untouched.

## Timing
- Reset values: O_rd_valid = 0, O_rd_data = 0, O_count = 0, O_full = 0, O_empty = 1, O_ovf = 0.
  - O_wr_ready = 1 during and after reset (count = 0).
- Write-to-read latency is 2 edges. A word pushed at edge N is popped at edge N+1, and O_rd_valid is visible after N+1.
- Throughput: one push and one pop per cycle sustained. Back-to-back reads with I_rd_ready held high give one word per cycle once RAM is non-empty.
- O_count, O_full, O_empty and O_ovf are registered and reflect the edge just taken.
- Reset asserted mid-burst: all state clears asynchronously. Words in flight are lost. No spurious O_rd_valid after deassertion.
- O_rd_data must stay stable while O_rd_valid & !I_rd_ready.

## Test plan
- Reset/idle with C_ADDRSIZE=2: assert I_rst mid-stream. Required: O_empty=1, O_count=0, O_rd_valid=0, O_wr_ready=1. Nothing appears at O_rd_data after release.
- Ordered stream, I_rd_ready=1: push 0x11, 0x22, 0x33 on consecutive cycles. Required: O_rd_valid first rises 2 edges after the 0x11 push. O_rd_data shows 0x11, 0x22, 0x33 on consecutive cycles. O_count peaks at 1.
- Stop mode fill, I_mode=0, I_rd_ready=0, C_MEMSIZE=4: offer 0x01..0x06 continuously.
  - After 0x01 is popped into the output register, RAM holds 0x02..0x05. O_count=4, O_full=1, O_wr_ready=0.
  - 0x06 is held off, not lost. O_ovf stays 0.
  - Then drain: the read sequence is 0x01..0x06.
- Circular mode, I_mode=1, I_rd_ready=0, C_MEMSIZE=4: push 0x01..0x07.
  - Output register holds 0x01. RAM reads back 0x04..0x07. O_ovf=1.
  - O_count stays 4.
- Full push+pop: RAM full, I_mode=1, consumer takes a word as a new word is pushed. Required: the next O_rd_data is the old rd_ptr word, O_count stays 4, O_ovf unchanged.
- Clear: with 3 words stored and O_ovf=1, pulse I_clear together with I_wr_valid=1. Required next cycle: O_count=0, O_empty=1, O_ovf=0, O_rd_valid=0. The pushed word never appears.

Source files
------------

// File: rtl/meas_buf.sv
// meas_buf: capture buffer for the measurement path.
// Words arrive over a valid/ready write port, sit in an internal RAM and
// leave in arrival order through a registered valid/ready read port.
// Runtime mode selects stop-when-full or circular overwrite; a sticky flag
// records that unread data was lost, and a synchronous clear empties it.
module meas_buf #(
    parameter int C_WORDSIZE = 8,
    parameter int C_ADDRSIZE = 10,
    parameter int C_MEMSIZE  = 1 << C_ADDRSIZE
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_clear,
    input  logic                  I_mode,
    input  logic                  I_wr_valid,
    input  logic [C_WORDSIZE-1:0] I_wr_data,
    output logic                  O_wr_ready,
    output logic                  O_rd_valid,
    output logic [C_WORDSIZE-1:0] O_rd_data,
    input  logic                  I_rd_ready,
    output logic [C_ADDRSIZE:0]   O_count,
    output logic                  O_full,
    output logic                  O_empty,
    output logic                  O_ovf
);

    localparam logic [C_ADDRSIZE:0]   LP_FULL_COUNT = (C_ADDRSIZE+1)'(C_MEMSIZE);
    localparam logic [C_ADDRSIZE:0]   LP_COUNT_ONE  = (C_ADDRSIZE+1)'(1);
    localparam logic [C_ADDRSIZE-1:0] LP_PTR_ONE    = C_ADDRSIZE'(1);

    logic [C_WORDSIZE-1:0] r_mem [C_MEMSIZE];
    logic [C_ADDRSIZE-1:0] r_wrPtr;
    logic [C_ADDRSIZE-1:0] r_rdPtr;
    logic [C_ADDRSIZE:0]   r_count;
    logic                  r_rdValid;
    logic [C_WORDSIZE-1:0] r_rdData;
    logic                  r_ovf;

    logic w_full;
    logic w_wrReady;
    logic w_push;
    logic w_pop;
    logic w_take;
    logic w_overwrite;

    // The pop refills the output register whenever it is empty or being
    // consumed this cycle. An overwrite only happens when the RAM is full in
    // circular mode and nothing leaves it in the same cycle; if a pop does
    // happen, the slot freed by the pop absorbs the push instead.
    assign w_full      = (r_count == LP_FULL_COUNT);
    assign w_wrReady   = I_mode | ~w_full;
    assign w_push      = I_wr_valid & w_wrReady;
    assign w_take      = r_rdValid & I_rd_ready;
    assign w_pop       = (r_count != '0) & (~r_rdValid | I_rd_ready);
    assign w_overwrite = w_push & w_full & ~w_pop;

    assign O_wr_ready = w_wrReady;
    assign O_rd_valid = r_rdValid;
    assign O_rd_data  = r_rdData;
    assign O_count    = r_count;
    assign O_full     = w_full;
    assign O_empty    = (r_count == '0) & ~r_rdValid;
    assign O_ovf      = r_ovf;

    // Store the accepted word; a clear in the same cycle discards the push.
    always_ff @(posedge I_clk) begin
        if (w_push && !I_clear) begin
            r_mem[r_wrPtr] <= I_wr_data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping; an overwrite drops the
    // oldest RAM word by advancing the read pointer alongside the write one.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (I_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + LP_PTR_ONE;
            end
            if (w_pop || w_overwrite) begin
                r_rdPtr <= r_rdPtr + LP_PTR_ONE;
            end
            if (w_push && !w_pop && !w_overwrite) begin
                r_count <= r_count + LP_COUNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LP_COUNT_ONE;
            end
            if (w_overwrite) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Output register: reading RAM with a non-blocking load gives the old
    // word when the same address is written in this cycle. The data is left
    // alone on clear or take so it never glitches while a consumer stalls.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else if (I_clear) begin
            r_rdValid <= 1'b0;
        end else if (w_pop) begin
            r_rdData  <= r_mem[r_rdPtr];
            r_rdValid <= 1'b1;
        end else if (w_take) begin
            r_rdValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_meas_buf.sv
// tb_meas_buf: self-checking bench for meas_buf with a 4-word RAM.
// A queue-based model of the buffer predicts every output after each edge;
// directed tables and sequences pin the documented corner cases.
module tb_meas_buf;

    localparam int LP_AW    = 2;
    localparam int LP_DW    = 8;
    localparam int LP_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             mode;
    logic             wrValid;
    logic [LP_DW-1:0] wrData;
    logic             wrReady;
    logic             rdValid;
    logic [LP_DW-1:0] rdData;
    logic             rdReady;
    logic [LP_AW:0]   count;
    logic             full;
    logic             empty;
    logic             ovf;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: RAM contents as a FIFO queue plus the output slot.
    byte unsigned modelQ[$];
    bit           modelValid = 1'b0;
    byte unsigned modelData  = 8'h00;
    bit           modelOvf   = 1'b0;
    byte unsigned takenLog[$];
    bit           lastPush;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       expValid;
        logic [7:0] expData;
        int         expCount;
    } vec_t;

    vec_t tbl[5];

    meas_buf #(
        .C_WORDSIZE(LP_DW),
        .C_ADDRSIZE(LP_AW),
        .C_MEMSIZE (LP_DEPTH)
    ) dut (
        .I_clk     (clk),
        .I_rst     (rst),
        .I_clear   (clear),
        .I_mode    (mode),
        .I_wr_valid(wrValid),
        .I_wr_data (wrData),
        .O_wr_ready(wrReady),
        .O_rd_valid(rdValid),
        .O_rd_data (rdData),
        .I_rd_ready(rdReady),
        .O_count   (count),
        .O_full    (full),
        .O_empty   (empty),
        .O_ovf     (ovf)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        int sz;
        sz = modelQ.size();
        checkOutput({tag, " rd_valid"}, 32'(rdValid), 32'(modelValid));
        if (modelValid) checkOutput({tag, " rd_data"}, 32'(rdData), 32'(modelData));
        checkOutput({tag, " count"}, 32'(count), 32'(sz));
        checkOutput({tag, " full"}, 32'(full), 32'(sz == LP_DEPTH));
        checkOutput({tag, " empty"}, 32'(empty), 32'(sz == 0 && !modelValid));
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(modelOvf));
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelValid = 1'b0;
        modelData  = 8'h00;
        modelOvf   = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the edge, then compare after it.
    task automatic applyStimulus(input logic c, input logic m, input logic wv, input logic [7:0] wd, input logic rr);
        bit isFull;
        bit expReady;
        bit doPush;
        bit doPop;
        clear   = c;
        mode    = m;
        wrValid = wv;
        wrData  = wd;
        rdReady = rr;
        #1;
        isFull   = (modelQ.size() == LP_DEPTH);
        expReady = m || !isFull;
        checkOutput("wr_ready", 32'(wrReady), 32'(expReady));
        if (!c && rdValid && rr) takenLog.push_back(rdData);
        doPush   = wv && expReady;
        doPop    = (modelQ.size() != 0) && (!modelValid || rr);
        lastPush = doPush && !c;
        if (c) begin
            modelQ.delete();
            modelValid = 1'b0;
            modelOvf   = 1'b0;
        end else begin
            if (doPop) begin
                modelData  = modelQ.pop_front();
                modelValid = 1'b1;
            end else if (modelValid && rr) begin
                modelValid = 1'b0;
            end
            if (doPush) begin
                if (modelQ.size() == LP_DEPTH) begin
                    void'(modelQ.pop_front());
                    modelOvf = 1'b1;
                end
                modelQ.push_back(wd);
            end
        end
        @(posedge clk);
        #1;
        checkModel("step");
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " rd_valid"}, 32'(rdValid), 32'd0);
        checkOutput({tag, " count"}, 32'(count), 32'd0);
        checkOutput({tag, " full"}, 32'(full), 32'd0);
        checkOutput({tag, " empty"}, 32'(empty), 32'd1);
        checkOutput({tag, " ovf"}, 32'(ovf), 32'd0);
        checkOutput({tag, " wr_ready"}, 32'(wrReady), 32'd1);
    endtask

    // Main test sequence.
    initial begin
        int word;
        int budget;

        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 1};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

        rst = 1'b1; clear = 1'b0; mode = 1'b0;
        wrValid = 1'b0; wrData = 8'h00; rdReady = 1'b0;
        #2;
        checkResetValues("reset");
        checkOutput("reset rd_data", 32'(rdData), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        $display("[TB] ordered stream");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, tbl[i].wv, tbl[i].wd, tbl[i].rr);
            checkOutput($sformatf("tbl%0d rd_valid", i), 32'(rdValid), 32'(tbl[i].expValid));
            checkOutput($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].expCount));
            if (tbl[i].expValid) checkOutput($sformatf("tbl%0d rd_data", i), 32'(rdData), 32'(tbl[i].expData));
        end

        $display("[TB] stop-mode fill");
        word = 1;
        repeat (8) begin
            applyStimulus(1'b0, 1'b0, word <= 6, 8'(word), 1'b0);
            if (lastPush) word++;
        end
        checkOutput("stop count", 32'(count), 32'd4);
        checkOutput("stop full", 32'(full), 32'd1);
        checkOutput("stop wr_ready", 32'(wrReady), 32'd0);
        checkOutput("stop ovf", 32'(ovf), 32'd0);
        checkOutput("stop rd_data", 32'(rdData), 32'h01);
        takenLog.delete();
        budget = 0;
        while (takenLog.size() < 6 && budget < 20) begin
            applyStimulus(1'b0, 1'b0, word <= 6, 8'(word), 1'b1);
            if (lastPush) word++;
            budget++;
        end
        checkOutput("stop drain size", 32'(takenLog.size()), 32'd6);
        for (int i = 0; i < 6 && i < takenLog.size(); i++)
            checkOutput($sformatf("stop drain %0d", i), 32'(takenLog[i]), 32'(i + 1));

        $display("[TB] circular overwrite");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int w = 1; w <= 7; w++) applyStimulus(1'b0, 1'b1, 1'b1, 8'(w), 1'b0);
        checkOutput("circ rd_data", 32'(rdData), 32'h01);
        checkOutput("circ count", 32'(count), 32'd4);
        checkOutput("circ ovf", 32'(ovf), 32'd1);
        takenLog.delete();
        budget = 0;
        while (takenLog.size() < 5 && budget < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
            budget++;
        end
        checkOutput("circ drain size", 32'(takenLog.size()), 32'd5);
        if (takenLog.size() == 5) begin
            checkOutput("circ drain 0", 32'(takenLog[0]), 32'h01);
            for (int i = 1; i < 5; i++)
                checkOutput($sformatf("circ drain %0d", i), 32'(takenLog[i]), 32'(i + 3));
        end

        $display("[TB] full push and pop");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int w = 0; w < 5; w++) applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'hA1 + w), 1'b0);
        checkOutput("fpp pre count", 32'(count), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hB0, 1'b1);
        checkOutput("fpp rd_data", 32'(rdData), 32'hA2);
        checkOutput("fpp count", 32'(count), 32'd4);
        checkOutput("fpp ovf", 32'(ovf), 32'd0);

        $display("[TB] clear");
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hB1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("pre-clear count", 32'(count), 32'd3);
        checkOutput("pre-clear ovf", 32'(ovf), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
        checkOutput("clear count", 32'(count), 32'd0);
        checkOutput("clear empty", 32'(empty), 32'd1);
        checkOutput("clear ovf", 32'(ovf), 32'd0);
        checkOutput("clear rd_valid", 32'(rdValid), 32'd0);
        takenLog.delete();
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checkOutput("clear nothing read", 32'(takenLog.size()), 32'd0);

        $display("[TB] random traffic");
        mode = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic m;
            m = ($urandom_range(0, 15) == 0) ? ~mode : mode;
            applyStimulus(1'($urandom_range(0, 63) == 0), m,
                          1'($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom_range(0, 2) == 0));
        end

        $display("[TB] reset mid-stream");
        for (int w = 0; w < 3; w++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'hC0 + w), 1'b0);
        wrValid = 1'b1;
        wrData  = 8'hCC;
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("midrst");
        @(posedge clk);
        #1;
        wrValid = 1'b0;
        rst = 1'b0;
        modelReset();
        takenLog.delete();
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("midrst nothing read", 32'(takenLog.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
